// File: rtl/leitor_tabuleiro_if.sv
// Move-entry interface between the chessboard reader and the game datapath.
// The reader drives the row strobe and committed move; the board/datapath side drives enable and columns.
interface leitor_tabuleiro_if;
  logic       habilita;
  logic [7:0] sensores;
  logic [7:0] linhaVarredura;
  logic [2:0] jogadaLinha;
  logic [2:0] jogadaColuna;
  logic       jogou;
  logic       erroMultiplo;
  logic [2:0] db_estado;

  modport master (
    input  habilita, sensores,
    output linhaVarredura, jogadaLinha, jogadaColuna, jogou, erroMultiplo, db_estado
  );

  modport slave (
    output habilita, sensores,
    input  linhaVarredura, jogadaLinha, jogadaColuna, jogou, erroMultiplo, db_estado
  );
endinterface

// File: rtl/leitor_tabuleiro.sv
// Scans an 8x8 reed-switch board, debounces whole frames and reports the pressed square.
// Define LEITOR_MULTIPLO_EN to detect multi-square frames (MULTIPLO state, erroMultiplo).
module leitor_tabuleiro #(
  parameter int SCAN_DIV  = 100,
  parameter int DEB_SCANS = 4
) (
  input logic                clock,
  input logic                reset,
  leitor_tabuleiro_if.master bus
);
  localparam int             CW       = $clog2(SCAN_DIV);
  localparam logic [CW-1:0]  CYC_LAST = CW'(SCAN_DIV - 1);
  localparam logic [3:0]     DEB      = 4'(DEB_SCANS);
  localparam logic [1:0]     T_NENHUM = 2'd0;
  localparam logic [1:0]     T_UNICO  = 2'd1;
`ifdef LEITOR_MULTIPLO_EN
  localparam logic [1:0]     T_MULTI  = 2'd2;
`endif

  typedef enum logic [2:0] {
    INATIVO = 3'd0, LIVRE = 3'd1, PRESSIONADO = 3'd2, MULTIPLO = 3'd3, ESPERA = 3'd4
  } estado_t;

  typedef struct packed {
    logic [1:0] tipo;
    logic [2:0] lin;
    logic [2:0] col;
  } quadro_t;

  logic [7:0]    sens_s1_q, sens_s2_q;
  estado_t       estado_q;
  logic [2:0]    row_q;
  logic [CW-1:0] cyc_q;
  logic [1:0]    cnt_q;
  logic [2:0]    first_l_q, first_c_q;
  quadro_t       prev_q;
  logic [3:0]    stab_q;
  logic [7:0]    linha_q;
  logic [2:0]    jl_q, jc_q;
  logic          jogou_q;
`ifdef LEITOR_MULTIPLO_EN
  logic          erro_q;
  logic [3:0]    pops;
  logic [4:0]    soma;
`endif

  logic [2:0] col_min;
  logic [1:0] cnt_d;
  logic [2:0] first_l_d, first_c_d;
  quadro_t    res;
  logic [3:0] stab_d;
  logic       amostra, fim_quadro, commit;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sens_s1_q <= 8'h00;
      sens_s2_q <= 8'h00;
    end else begin
      sens_s1_q <= bus.sensores;
      sens_s2_q <= sens_s1_q;
    end
  end

  always_comb begin
    col_min = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (sens_s2_q[i]) col_min = 3'(i);
    end
`ifdef LEITOR_MULTIPLO_EN
    pops = 4'd0;
    for (int i = 0; i < 8; i++) pops = pops + {3'b000, sens_s2_q[i]};
    soma  = {3'b000, cnt_q} + {1'b0, pops};
    cnt_d = (soma >= 5'd2) ? 2'd2 : soma[1:0];
`else
    cnt_d = {1'b0, cnt_q[0] | (|sens_s2_q)};
`endif
    if (cnt_q == 2'd0 && (|sens_s2_q)) begin
      first_l_d = row_q;
      first_c_d = col_min;
    end else begin
      first_l_d = first_l_q;
      first_c_d = first_c_q;
    end
    // Coordinates only distinguish UNICO frames; NENHUM/MULTIPLO compare by type alone.
    res.tipo = cnt_d;
    res.lin  = (cnt_d == T_UNICO) ? first_l_d : 3'd0;
    res.col  = (cnt_d == T_UNICO) ? first_c_d : 3'd0;

    amostra    = bus.habilita && (estado_q != INATIVO) && (cyc_q == CYC_LAST);
    fim_quadro = amostra && (row_q == 3'd7);
    if (res == prev_q) stab_d = (stab_q >= DEB) ? DEB : stab_q + 4'd1;
    else               stab_d = 4'd1;
    commit = fim_quadro && (stab_d == DEB);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q  <= INATIVO;
      row_q     <= 3'd0;
      cyc_q     <= '0;
      cnt_q     <= 2'd0;
      first_l_q <= 3'd0;
      first_c_q <= 3'd0;
      prev_q    <= '0;
      stab_q    <= 4'd0;
      linha_q   <= 8'h00;
      jl_q      <= 3'd0;
      jc_q      <= 3'd0;
      jogou_q   <= 1'b0;
`ifdef LEITOR_MULTIPLO_EN
      erro_q    <= 1'b0;
`endif
    end else if (!bus.habilita) begin
      estado_q  <= INATIVO;
      row_q     <= 3'd0;
      cyc_q     <= '0;
      cnt_q     <= 2'd0;
      first_l_q <= 3'd0;
      first_c_q <= 3'd0;
      prev_q    <= '0;
      stab_q    <= 4'd0;
      linha_q   <= 8'h00;
      jl_q      <= 3'd0;
      jc_q      <= 3'd0;
      jogou_q   <= 1'b0;
`ifdef LEITOR_MULTIPLO_EN
      erro_q    <= 1'b0;
`endif
    end else if (estado_q == INATIVO) begin
      estado_q <= LIVRE;
    end else begin
      linha_q <= 8'd1 << row_q;
      if (cyc_q == CYC_LAST) begin
        cyc_q <= '0;
        row_q <= row_q + 3'd1;
      end else begin
        cyc_q <= cyc_q + 1'b1;
      end

      if (fim_quadro) begin
        cnt_q     <= 2'd0;
        first_l_q <= 3'd0;
        first_c_q <= 3'd0;
        prev_q    <= res;
        stab_q    <= stab_d;
      end else if (amostra) begin
        cnt_q     <= cnt_d;
        first_l_q <= first_l_d;
        first_c_q <= first_c_d;
      end

      if (commit) begin
        case (estado_q)
          LIVRE: begin
            if (res.tipo == T_UNICO) begin
              estado_q <= PRESSIONADO;
              jl_q     <= res.lin;
              jc_q     <= res.col;
              jogou_q  <= 1'b1;
            end
`ifdef LEITOR_MULTIPLO_EN
            else if (res.tipo == T_MULTI) begin
              estado_q <= MULTIPLO;
              erro_q   <= 1'b1;
            end
`endif
          end
          PRESSIONADO: begin
            if (res.tipo == T_NENHUM) begin
              estado_q <= LIVRE;
              jogou_q  <= 1'b0;
            end
`ifdef LEITOR_MULTIPLO_EN
            else if (res.tipo == T_MULTI) begin
              estado_q <= MULTIPLO;
              jogou_q  <= 1'b0;
              erro_q   <= 1'b1;
            end
`endif
            // A slide to another square without release is not a new move.
            else if (res.lin != jl_q || res.col != jc_q) begin
              estado_q <= ESPERA;
              jogou_q  <= 1'b0;
            end
          end
`ifdef LEITOR_MULTIPLO_EN
          MULTIPLO: begin
            if (res.tipo == T_NENHUM) begin
              estado_q <= LIVRE;
              erro_q   <= 1'b0;
            end
          end
`endif
          ESPERA: begin
            if (res.tipo == T_NENHUM) estado_q <= LIVRE;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.linhaVarredura = linha_q;
  assign bus.jogadaLinha    = jl_q;
  assign bus.jogadaColuna   = jc_q;
  assign bus.jogou          = jogou_q;
  assign bus.db_estado      = estado_q;
`ifdef LEITOR_MULTIPLO_EN
  assign bus.erroMultiplo   = erro_q;
`else
  assign bus.erroMultiplo   = 1'b0;
`endif
endmodule

// File: tb/tb_leitor_tabuleiro.sv
// Self-checking bench for leitor_tabuleiro (SCAN_DIV=4, DEB_SCANS=2, 32-cycle frame).
// Expectations follow LEITOR_MULTIPLO_EN when the bench is built with it.
module tb_leitor_tabuleiro;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] board = 64'd0;
  int          n_pass = 0;
  int          n_tot  = 0;

  always #5 clock = ~clock;

  leitor_tabuleiro_if bus();

  leitor_tabuleiro #(.SCAN_DIV(4), .DEB_SCANS(2)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  // Board model: the driven row returns its eight reed switches.
  always_comb begin
    bus.sensores = 8'h00;
    for (int r = 0; r < 8; r++) begin
      if (bus.linhaVarredura[r]) bus.sensores = board[r*8 +: 8];
    end
  end

  typedef struct {
    logic [63:0] tab;
    int          jogou, erro, estado, lin, col;
    string       nome;
  } vetor_t;

  vetor_t vt[9];

  function automatic logic [63:0] sq(input int r, input int c);
    logic [63:0] um;
    um = 64'd1;
    return um << (r * 8 + c);
  endfunction

  task automatic chk(input string nome, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nome, act, exp);
  endtask

  task automatic ciclo();
    @(posedge clock);
    #1;
  endtask

  task automatic espera_estado(input int est, input int max, input string nome);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      ciclo();
      if (int'(bus.db_estado) == est) ok = 1'b1;
    end
    chk(nome, int'(bus.db_estado), est);
  endtask

  task automatic chk_saidas(input string nome, input int j, input int e, input int s,
                            input int l, input int c);
    chk({nome, ".jogou"},  int'(bus.jogou), j);
    chk({nome, ".erro"},   int'(bus.erroMultiplo), e);
    chk({nome, ".estado"}, int'(bus.db_estado), s);
    chk({nome, ".lin"},    int'(bus.jogadaLinha), l);
    chk({nome, ".col"},    int'(bus.jogadaColuna), c);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          visto;
    logic [7:0]  linha_ant;

    vt[0] = '{64'd0,                 0, 0, 1, 0, 0, "vazio"};
    vt[1] = '{sq(5, 2),              1, 0, 2, 5, 2, "q52"};
    vt[2] = '{64'd0,                 0, 0, 1, 5, 2, "solta52"};
`ifdef LEITOR_MULTIPLO_EN
    vt[3] = '{sq(1, 1) | sq(6, 3),   0, 1, 3, 5, 2, "duplo_linhas"};
    vt[4] = '{64'd0,                 0, 0, 1, 5, 2, "solta_duplo"};
    vt[5] = '{sq(4, 6) | sq(4, 1),   0, 1, 3, 5, 2, "duplo_linha4"};
    vt[6] = '{64'd0,                 0, 0, 1, 5, 2, "solta_duplo4"};
`else
    vt[3] = '{sq(1, 1) | sq(6, 3),   1, 0, 2, 1, 1, "duplo_linhas"};
    vt[4] = '{64'd0,                 0, 0, 1, 1, 1, "solta_duplo"};
    vt[5] = '{sq(4, 6) | sq(4, 1),   1, 0, 2, 4, 1, "duplo_linha4"};
    vt[6] = '{64'd0,                 0, 0, 1, 4, 1, "solta_duplo4"};
`endif
    vt[7] = '{sq(0, 7),              1, 0, 2, 0, 7, "q07"};
    vt[8] = '{64'd0,                 0, 0, 1, 0, 7, "solta07"};

    bus.habilita = 1'b0;
    repeat (3) ciclo();
    chk("rst.linha", int'(bus.linhaVarredura), 0);
    chk_saidas("rst", 0, 0, 0, 0, 0);

    reset = 1'b1;
    bus.habilita = 1'b1;
    ciclo();
    chk("ini.estado", int'(bus.db_estado), 1);
    chk("ini.linha", int'(bus.linhaVarredura), 0);
    for (int i = 0; i < 64; i++) begin
      ciclo();
      chk("varredura", int'(bus.linhaVarredura), 1 << ((i / 4) % 8));
    end
    chk("varredura.jogou", int'(bus.jogou), 0);

    for (int v = 0; v < 9; v++) begin
      board = vt[v].tab;
      repeat (128) ciclo();
      chk_saidas(vt[v].nome, vt[v].jogou, vt[v].erro, vt[v].estado, vt[v].lin, vt[v].col);
    end

    // One-frame glitch on (3,7), aligned to a frame start.
    linha_ant = bus.linhaVarredura;
    visto = 1'b0;
    for (int i = 0; i < 40 && !visto; i++) begin
      ciclo();
      if (bus.linhaVarredura == 8'h01 && linha_ant != 8'h01) visto = 1'b1;
      linha_ant = bus.linhaVarredura;
    end
    chk("glitch.alinha", int'(visto), 1);
    board = sq(3, 7);
    repeat (32) ciclo();
    board = 64'd0;
    visto = 1'b0;
    for (int i = 0; i < 100; i++) begin
      ciclo();
      if (bus.jogou || bus.db_estado != 3'd1) visto = 1'b1;
    end
    chk("glitch.sem_jogada", int'(visto), 0);

    // Slide from (2,2) to (2,3) without release.
    board = sq(2, 2);
    espera_estado(2, 99, "desliza.press22");
    chk_saidas("desliza.q22", 1, 0, 2, 2, 2);
    board = sq(2, 3);
    espera_estado(4, 99, "desliza.espera");
    chk("desliza.jogou", int'(bus.jogou), 0);
    repeat (96) ciclo();
    chk_saidas("desliza.mantem", 0, 0, 4, 2, 2);
    board = 64'd0;
    espera_estado(1, 99, "desliza.solta");
    chk("desliza.solta_jogou", int'(bus.jogou), 0);
    board = sq(2, 3);
    espera_estado(2, 99, "desliza.novo23");
    chk_saidas("desliza.q23", 1, 0, 2, 2, 3);

    // Asynchronous reset while a move is held.
    reset = 1'b0;
    #1;
    chk("rst_async.linha", int'(bus.linhaVarredura), 0);
    chk_saidas("rst_async", 0, 0, 0, 0, 0);
    ciclo();
    reset = 1'b1;
    board = 64'd0;
    repeat (45) ciclo();
    chk("hab.estado_livre", int'(bus.db_estado), 1);
    chk("hab.linha_ativa", int'(bus.linhaVarredura != 8'h00), 1);
    bus.habilita = 1'b0;
    ciclo();
    chk("hab.linha", int'(bus.linhaVarredura), 0);
    chk("hab.estado", int'(bus.db_estado), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/leitor_tabuleiro.md
# leitor_tabuleiro

Scans the 8×8 reed-switch matrix under the physical chessboard, debounces it across whole scan frames, and produces the player's square as `jogadaLinha`/`jogadaColuna` with a `jogou` level. It is the producer end of the move-entry interface that the game datapath registers, compares and edge-detects. One frame is 8 rows × `SCAN_DIV` cycles.

## Interface
- `SCAN_DIV`, 100: clock cycles each row is driven; must be ≥ 4.
- `DEB_SCANS`, 4: number of consecutive identical frames required to commit a result; range 1..15.
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `habilita`  in  1  scan enable; low forces INATIVO.
- `sensores`  in  8  asynchronous column returns for the driven row; bit c = column c; 1 = piece pressed.
- `linhaVarredura`  out  8  one-hot, active-high row drive.
- `jogadaLinha`  out  3  committed row.
- `jogadaColuna`  out  3  committed column.
- `jogou`  out  1  high while a single square is committed.
- `erroMultiplo`  out  1  high while more than one square is committed.
- `db_estado`  out  3  FSM state code.

## Operation
- Input path: `sensores` passes through a 2-flop synchronizer.
- Row scanning:
  - A row counter (0..7) and a cycle counter (0..`SCAN_DIV`-1) run while `habilita`=1.
  - `linhaVarredura` = 1 << row.
  - The synchronized columns are sampled on cycle `SCAN_DIV`-1 of each row.
- Frame accumulator:
  - Pressed-square count, saturating at 2.
  - Coordinate of the first pressed square. Priority is lowest row, then lowest column.
  - At the row-7 sample the frame result is one of NENHUM, UNICO(l,c) or MULTIPLO. The accumulator then clears.
- Debounce:
  - If the frame result equals the previous frame result, the stable counter increments, saturating at `DEB_SCANS`. Otherwise it loads 1.
  - When the counter reaches `DEB_SCANS`, the result becomes the committed result.
- FSM (codes 0..4), transitions evaluated on each commit:
  - INATIVO(0), entered whenever `habilita`=0.
    - `linhaVarredura`=0; all counters, the accumulator and the previous-frame result are cleared; outputs are 0.
    - On `habilita`=1, go to LIVRE and scanning starts at row 0, cycle 0.
  - LIVRE(1): on commit UNICO, latch coordinates and go to PRESSIONADO. On commit MULTIPLO, go to MULTIPLO.
  - PRESSIONADO(2): `jogou`=1.
    - Commit of the same UNICO: stay.
    - Commit NENHUM: go to LIVRE.
    - Commit MULTIPLO: go to MULTIPLO.
    - Commit of a different UNICO: go to ESPERA (a slide without release is not a new move).
  - MULTIPLO(3): `erroMultiplo`=1. Only a commit of NENHUM leaves this state, to LIVRE.
  - ESPERA(4): all outputs low. Only a commit of NENHUM leaves this state, to LIVRE.
- `jogadaLinha` and `jogadaColuna` hold their latched value in every state except INATIVO, where they are 0.

## Timing
- All outputs are registered. Reset values: `linhaVarredura`=8'h00, `jogadaLinha`=0, `jogadaColuna`=0, `jogou`=0, `erroMultiplo`=0, `db_estado`=0.
- The first cycle after reset release with `habilita`=1 enters LIVRE. `linhaVarredura`=8'h01 one cycle later.
- Outputs change one cycle after the committing row-7 sample.
- Latency from a stable press to `jogou` is between (`DEB_SCANS`-1)×8×`SCAN_DIV`+3 and (`DEB_SCANS`+1)×8×`SCAN_DIV`+3 cycles. Release latency is the same.
- A frame differing in any way from the previous frame restarts debounce. A single-frame glitch never commits when `DEB_SCANS` ≥ 2.
- `habilita` falling mid-frame: INATIVO on the next cycle and the partial frame is discarded.
- `reset` asserted at any time: all state and outputs clear asynchronously.

## Configuration
- `LEITOR_MULTIPLO_EN` defined:
  - MULTIPLO frame results and the MULTIPLO state exist as described.
  - `erroMultiplo` is driven by the FSM.
- `LEITOR_MULTIPLO_EN` undefined:
  - The count is not kept. Any frame with ≥ 1 press is UNICO at the priority square.
  - The MULTIPLO state code is never reached.
  - `erroMultiplo` is tied to 0.

## Test plan
All scenarios use `SCAN_DIV`=4 and `DEB_SCANS`=2, giving a 32-cycle frame.
- Reset, then `habilita`=1 with no presses -> `linhaVarredura` steps 01,02,04,…,80 with 4 cycles each and repeats; `db_estado`=1; `jogou`=0.
- Hold square (5,2) -> `jogou`=1 with `jogadaLinha`=5, `jogadaColuna`=2 within 99 cycles. Release -> `jogou`=0 within 99 cycles and coordinates hold 5,2.
- Square (3,7) pressed for exactly one frame -> `jogou` never asserts and `db_estado` stays 1.
- Hold (1,1) and (6,3) together:
  - With the macro -> `erroMultiplo`=1, `jogou`=0, `db_estado`=3.
  - Without the macro -> `jogou`=1 with coordinates (1,1).
- Hold (2,2) until `jogou`=1, then move to (2,3) with no gap -> `jogou` falls, `db_estado`=4, and it stays low until everything is released. A fresh press of (2,3) then gives `jogou`=1.
- Assert `reset` while `jogou`=1 -> all outputs 0 immediately. Drop `habilita` mid-frame -> `linhaVarredura`=0 and `db_estado`=0 the next cycle.
